// File: rtl/sprite_mem_server_if.sv
// Sprite store bus: the renderer read port, the frame timing pulse, and the
// CPU-side byte-stream loader with its status flags.
interface sprite_mem_server_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] sprite_addr;
  logic [15:0]       sprite_data;
  logic              frame_start;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [7:0]        ld_byte;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_commit;
  logic              swap_pending;
  logic              active_bank;
  logic              ld_err;

  // Renderer + loader side: drives addresses, pulses and bytes.
  modport master (
    output sprite_addr, frame_start, ld_start, ld_base, ld_byte, ld_valid, ld_commit,
    input  sprite_data, ld_ready, swap_pending, active_bank, ld_err
  );

  // Sprite store side.
  modport slave (
    input  sprite_addr, frame_start, ld_start, ld_base, ld_byte, ld_valid, ld_commit,
    output sprite_data, ld_ready, swap_pending, active_bank, ld_err
  );
endinterface

// File: rtl/sprite_mem_server.sv
// Double-buffered RGB565 sprite store. The renderer reads the display bank with
// a fixed one-cycle latency; the loader assembles little-endian byte pairs into
// the hidden bank; a commit swaps the banks on the next frame start.
module sprite_mem_server #(
  parameter int          DEPTH       = 4096,
  parameter int          ADDR_W      = 13,
  parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
  input logic                pix_clk,
  input logic                rst_n,
  sprite_mem_server_if.slave bus
);
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    FULL,
    WAIT_SWAP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ld_ptr;
  logic [7:0]        lo_byte;
  logic              bank;
  logic              pending;
  logic              err;
  logic [15:0]       rd_data_p1;
  logic [15:0]       mem [0:1][0:DEPTH-1];

  logic              byte_acc;
  logic              wr_en;
  logic              start_ok;
  logic [15:0]       wr_word;

  // Address check done one bit wider so DEPTH == 2**ADDR_W still compares correctly.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  // A commit in the same cycle closes the loader, so it wins over a byte.
  assign bus.ld_ready     = ((state == LOAD_LO) || (state == LOAD_HI)) && !bus.ld_commit;
  assign byte_acc         = bus.ld_valid && bus.ld_ready;
  assign start_ok         = in_range(bus.ld_base);
  assign wr_en            = (state == LOAD_HI) && byte_acc && !bus.ld_start;
  assign wr_word          = {bus.ld_byte, lo_byte};
  assign bus.sprite_data  = rd_data_p1;
  assign bus.swap_pending = pending;
  assign bus.active_bank  = bank;
  assign bus.ld_err       = err;

  // ---- stage p0 -> p1: registered read of the display bank ----
  // Read register: display bank word, or TRANSPARENT outside the sprite store.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
    end else if (in_range(bus.sprite_addr)) begin
      rd_data_p1 <= mem[bank][bus.sprite_addr[IDX_W-1:0]];
    end else begin
      rd_data_p1 <= TRANSPARENT;
    end
  end

  // Hidden-bank write port plus low-byte holding register (data, never reset).
  always_ff @(posedge pix_clk) begin
    if (wr_en) begin
      mem[~bank][ld_ptr[IDX_W-1:0]] <= wr_word;
    end
    if ((state == LOAD_LO) && byte_acc) begin
      lo_byte <= bus.ld_byte;
    end
  end

  // Loader FSM: pointer, error flag, swap request and bank select.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ld_ptr  <= '0;
      bank    <= 1'b0;
      pending <= 1'b0;
      err     <= 1'b0;
    end else if ((state != WAIT_SWAP) && bus.ld_start) begin
      // A start outside WAIT_SWAP always (re)starts, discarding any half word.
      if (start_ok) begin
        ld_ptr <= bus.ld_base;
        err    <= 1'b0;
        state  <= LOAD_LO;
      end else begin
        err   <= 1'b1;
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        LOAD_LO, LOAD_HI: begin
          if (bus.ld_commit) begin
            // Committing with a low byte still held means an odd byte count.
            if (state == LOAD_HI) begin
              err <= 1'b1;
            end
            pending <= 1'b1;
            state   <= WAIT_SWAP;
          end else if (byte_acc) begin
            if (state == LOAD_LO) begin
              state <= LOAD_HI;
            end else begin
              ld_ptr <= ld_ptr + 1'b1;
              state  <= (ld_ptr == LAST) ? FULL : LOAD_LO;
            end
          end
        end
        FULL: begin
          if (bus.ld_commit) begin
            pending <= 1'b1;
            state   <= WAIT_SWAP;
          end
        end
        WAIT_SWAP: begin
          // The read taken on this edge still used the old bank.
          if (bus.frame_start) begin
            bank    <= ~bank;
            pending <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
